button_event_fifo: RTL and testbench

Sits directly downstream of the per-button debounce stages. It collects their one-cycle press pulses, serialises simultaneous presses by fixed priority, and buffers the resulting event codes in a small first-word-fall-through FIFO. The game logic drains the FIFO at its own pace using a valid/ready handshake, typically once per frame tick. No press is lost unless the same button is pressed again before its earlier press has been queued.

---
 rtl/button_event_fifo.sv | 94 +++++++++
 tb/tb_button_event_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_fifo.sv
// Press-event collector: per-button pending bits, a fixed-priority serialiser
// and a small first-word-fall-through FIFO drained with a valid/ready handshake.

module btn_pend_cell (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    input  logic push,
    output logic pend,
    output logic lost
);
    // A new press landing on the edge this bit is pushed re-arms it rather than being lost
    assign lost = pulse & pend & ~push;

    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= pulse | (pend & ~push);
    end
endmodule

module button_event_fifo #(
    parameter int NUM_BTN = 4,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    localparam int CODE_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pb_pulse,
    output logic               ev_valid,
    output logic [CODE_W-1:0]  ev_code,
    input  logic               ev_ready,
    output logic [PTR_W:0]     ev_count,
    output logic               overflow,
    input  logic               clr_overflow
);
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] lost;
    logic [NUM_BTN-1:0] push_sel;
    logic [CODE_W-1:0]  push_code;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CODE_W-1:0]  mem [DEPTH];
    logic               full;
    logic               push;
    logic               pop;

    assign full     = (ev_count == (PTR_W+1)'(DEPTH));
    assign ev_valid = (ev_count != '0);
    assign pop      = ev_valid & ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push     = (|pending) & (~full | pop);
    assign ev_code  = ev_valid ? mem[rd_ptr] : '0;

    always_comb begin
        push_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) push_code = CODE_W'(i);
        end
        push_sel = '0;
        if (push) push_sel = pending & (~pending + NUM_BTN'(1));
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_pend_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .pulse (pb_pulse[i]),
            .push  (push_sel[i]),
            .pend  (pending[i]),
            .lost  (lost[i])
        );
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      ev_count <= ev_count + (PTR_W+1)'(1);
            else if (pop && !push) ev_count <= ev_count - (PTR_W+1)'(1);
            if (|lost)             overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_button_event_fifo.sv
// Bench for button_event_fifo: fixed vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.

module tb_button_event_fifo;
    localparam int NB = 4;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] pb_pulse = '0;
    logic          ev_valid;
    logic [1:0]    ev_code;
    logic          ev_ready = 1'b0;
    logic [3:0]    ev_count;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model: queued codes, pending presses, sticky loss flag
    int       mq[$];
    bit [3:0] mp;
    bit       mo;

    button_event_fifo #(.NUM_BTN(NB), .DEPTH(DP), .PTR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_pulse     (pb_pulse),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_ready     (ev_ready),
        .ev_count     (ev_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit [3:0] pb, input bit rdy, input bit clr, input bit r);
        bit popn, pushn, loss;
        int idx;
        if (r) begin
            mq.delete();
            mp = '0;
            mo = 1'b0;
            return;
        end
        popn  = (mq.size() > 0) && rdy;
        pushn = (mp != 0) && ((mq.size() < DP) || popn);
        idx   = -1;
        for (int i = 0; i < NB; i++) if (mp[i] && idx < 0) idx = i;
        loss = 1'b0;
        for (int i = 0; i < NB; i++)
            if (pb[i] && mp[i] && !(pushn && idx == i)) loss = 1'b1;
        if (popn) void'(mq.pop_front());
        if (pushn) begin
            mq.push_back(idx);
            mp[idx] = 1'b0;
        end
        mp = mp | pb;
        if (loss)     mo = 1'b1;
        else if (clr) mo = 1'b0;
    endtask

    // one clock: drive inputs, advance the model at the edge, compare just after it
    task automatic cycle(input bit [3:0] pb, input bit rdy, input bit clr, input bit r);
        pb_pulse     = pb;
        ev_ready     = rdy;
        clr_overflow = clr;
        rst          = r;
        @(posedge clk);
        model_step(pb, rdy, clr, r);
        #1;
        chk("model_valid", int'(ev_valid), int'(mq.size() != 0));
        chk("model_count", int'(ev_count), mq.size());
        chk("model_ovf", int'(overflow), int'(mo));
        if (mq.size() != 0) chk("model_code", int'(ev_code), mq[0]);
    endtask

    typedef struct {
        bit [3:0] pb;
        bit       rdy;
        bit       clr;
        bit       r;
        bit       v;
        int       code;
        int       cnt;
        bit       ovf;
    } vec_t;

    vec_t tbl[17];
    int   exp_order[10];

    initial begin
        tbl[0]  = '{4'b1111, 0, 0, 1, 0, 0, 0, 0};  // reset, pulses ignored
        tbl[1]  = '{4'b0100, 0, 0, 0, 0, 0, 0, 0};  // press lands in pending
        tbl[2]  = '{4'b0000, 0, 0, 0, 1, 2, 1, 0};  // visible two edges later
        tbl[3]  = '{4'b0000, 0, 0, 0, 1, 2, 1, 0};  // held while not ready
        tbl[4]  = '{4'b0000, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{4'b1011, 0, 0, 0, 0, 0, 0, 0};  // simultaneous presses
        tbl[6]  = '{4'b0000, 0, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{4'b0000, 0, 0, 0, 1, 0, 2, 0};
        tbl[8]  = '{4'b0000, 0, 0, 0, 1, 0, 3, 0};
        tbl[9]  = '{4'b0000, 1, 0, 0, 1, 1, 2, 0};
        tbl[10] = '{4'b0000, 1, 0, 0, 1, 3, 1, 0};
        tbl[11] = '{4'b0000, 1, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{4'b0100, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{4'b0100, 0, 0, 0, 1, 2, 1, 0};  // re-press on its push edge
        tbl[14] = '{4'b0000, 0, 0, 0, 1, 2, 2, 0};
        tbl[15] = '{4'b0000, 1, 0, 0, 1, 2, 1, 0};
        tbl[16] = '{4'b0000, 1, 0, 0, 0, 0, 0, 0};

        cycle(4'b0000, 0, 0, 1);
        foreach (tbl[k]) begin
            cycle(tbl[k].pb, tbl[k].rdy, tbl[k].clr, tbl[k].r);
            chk($sformatf("tbl%0d_valid", k), int'(ev_valid), int'(tbl[k].v));
            chk($sformatf("tbl%0d_count", k), int'(ev_count), tbl[k].cnt);
            chk($sformatf("tbl%0d_ovf", k), int'(overflow), int'(tbl[k].ovf));
            if (tbl[k].v || tbl[k].r) chk($sformatf("tbl%0d_code", k), int'(ev_code), tbl[k].code);
        end

        // ten spaced presses into a stalled consumer, then one repeat press
        for (int k = 0; k < 10; k++) begin
            cycle(4'(1 << (k % 4)), 0, 0, 0);
            repeat (3) cycle(4'b0000, 0, 0, 0);
            exp_order[k] = k % 4;
        end
        chk("sat_count", int'(ev_count), 8);
        chk("sat_ovf_before", int'(overflow), 0);
        cycle(4'b0001, 0, 0, 0);
        chk("sat_ovf_after", int'(overflow), 1);

        // drain: full FIFO pops and pushes on the same edge
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("drain%0d_valid", k), int'(ev_valid), 1);
            chk($sformatf("drain%0d_code", k), int'(ev_code), exp_order[k]);
            cycle(4'b0000, 1, 0, 0);
            if (k < 2) chk($sformatf("drain%0d_full_count", k), int'(ev_count), 8);
        end
        chk("drain_empty", int'(ev_valid), 0);
        cycle(4'b0000, 0, 1, 0);
        chk("clr_ovf", int'(overflow), 0);

        // back-to-back presses of one button until the FIFO is full and one is lost
        for (int k = 0; k < 9; k++) cycle(4'b1000, 0, 0, 0);
        chk("b2b_count", int'(ev_count), 8);
        chk("b2b_no_loss", int'(overflow), 0);
        cycle(4'b1000, 0, 0, 0);
        chk("b2b_loss", int'(overflow), 1);
        cycle(4'b1000, 0, 1, 0);
        chk("set_beats_clr", int'(overflow), 1);
        cycle(4'b0000, 0, 1, 0);
        chk("clr_after_loss", int'(overflow), 0);

        // reset in the middle of traffic
        repeat (4) cycle(4'b0000, 1, 0, 0);
        cycle(4'b0010, 0, 0, 0);
        chk("pre_rst_count", int'(ev_count), 5);
        cycle(4'b1111, 0, 0, 1);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(ev_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_code", int'(ev_code), 0);
        repeat (3) cycle(4'b0000, 0, 0, 0);
        chk("post_rst_count", int'(ev_count), 0);

        // randomized traffic: slow consumer first, then a fast one
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] pb;
            bit       rdy;
            pb  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rdy = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(pb, rdy, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
